// File: rtl/square_pkg.sv
// Shared types and constants for the iterative squarer.
package square_pkg;

   localparam int SQ_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } sq_state_t;

endpackage

// File: rtl/square_step.sv
// One shift-and-add step of the squarer: adds the shifted multiplicand when the
// current multiplier LSB is set, and consumes that multiplier bit.
module square_step
   import square_pkg::*;
#(
   parameter int WIDTH = SQ_WIDTH,
   parameter int HALF  = WIDTH / 2,
   parameter int CW    = $clog2(HALF + 1)
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] mcand,
   input  logic [HALF-1:0]  mplier,
   input  logic [CW-1:0]    cnt,
   output logic [WIDTH-1:0] acc_next,
   output logic [HALF-1:0]  mplier_next
);

   // Truncation to WIDTH bits is lossless: mcand < 2^HALF and cnt < HALF.
   assign acc_next    = mplier[0] ? acc + (mcand << cnt) : acc;
   assign mplier_next = mplier >> 1;

endmodule

// File: rtl/square_calculator.sv
// Iterative unsigned squarer (out = in*in), one multiplier bit per falling edge.
// Optional SQUARE_EARLY_EXIT_EN finishes as soon as the multiplier runs out of set bits.
module square_calculator
   import square_pkg::*;
#(
   parameter int WIDTH = SQ_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             error,
   output logic             done,
   output logic             busy,
   output sq_state_t        state
);

   localparam int HALF = WIDTH / 2;
   localparam int CW   = $clog2(HALF + 1);

   // Handshake: start is sampled on every falling edge and always wins; done stays
   // high with out/error valid until the next start; busy is high while iterating.

   sq_state_t        state_n;
   logic [WIDTH-1:0] acc, acc_n, mcand, mcand_n, step_acc;
   logic [HALF-1:0]  mplier, mplier_n, step_mplier;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] out_n;
   logic             error_n, done_n, busy_n, finish;

   square_step #(
      .WIDTH (WIDTH),
      .HALF  (HALF),
      .CW    (CW)
   ) u_step (
      .acc         (acc),
      .mcand       (mcand),
      .mplier      (mplier),
      .cnt         (cnt),
      .acc_next    (step_acc),
      .mplier_next (step_mplier)
   );

`ifdef SQUARE_EARLY_EXIT_EN
   assign finish = (cnt == CW'(HALF)) || (mplier == '0);
`else
   assign finish = (cnt == CW'(HALF));
`endif

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         out    <= '0;
         error  <= 1'b0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         acc    <= acc_n;
         mcand  <= mcand_n;
         mplier <= mplier_n;
         cnt    <= cnt_n;
         out    <= out_n;
         error  <= error_n;
         done   <= done_n;
         busy   <= busy_n;
      end
   end

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      mcand_n  = mcand;
      mplier_n = mplier;
      cnt_n    = cnt;
      out_n    = out;
      error_n  = error;
      done_n   = done;
      busy_n   = busy;
      if (start) begin
         if (|in[WIDTH-1:HALF]) begin
            error_n = 1'b1;
            done_n  = 1'b1;
            out_n   = '0;
            busy_n  = 1'b0;
            state_n = DONE;
         end else begin
            // out deliberately keeps the previous result while the new one is computed.
            mcand_n  = in;
            mplier_n = in[HALF-1:0];
            acc_n    = '0;
            cnt_n    = '0;
            error_n  = 1'b0;
            done_n   = 1'b0;
            busy_n   = 1'b1;
            state_n  = CALC;
         end
      end else if (state == CALC) begin
         if (finish) begin
            out_n   = acc;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
         end else begin
            acc_n    = step_acc;
            mplier_n = step_mplier;
            cnt_n    = cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_square_calculator.sv
// Scoreboard bench for square_calculator: drivers push expected {latency, error, out}
// records from an arithmetic model; a monitor pops and compares when done appears.
module tb_square_calculator;
   import square_pkg::*;

   localparam int WIDTH = 32;
   localparam int HALF  = WIDTH / 2;
   localparam int EW    = WIDTH + 9;

   logic             clk, rst, start;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic             error, done, busy;
   sq_state_t        state;

   int checks   = 0;
   int failures = 0;

   logic [EW-1:0]    exp_q[$];
   logic             pending = 1'b0;
   int               edges   = 0;
   logic [WIDTH-1:0] model_out = '0;

   square_calculator #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in    (in),
      .out   (out),
      .error (error),
      .done  (done),
      .busy  (busy),
      .state (state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: square by plain arithmetic, latency from the operand's bit length.
   function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] v);
      logic [2*WIDTH-1:0] sq;
      logic [7:0]         lat;
      int                 bl;
      if ((v >> HALF) != 0) return {8'd0, 1'b1, {WIDTH{1'b0}}};
      sq = {{WIDTH{1'b0}}, v} * {{WIDTH{1'b0}}, v};
      bl = 0;
      for (int i = 0; i < WIDTH; i++) if (v[i]) bl = i + 1;
`ifdef SQUARE_EARLY_EXIT_EN
      lat = 8'(bl + 1);
`else
      lat = 8'(HALF + 1);
`endif
      return {lat, 1'b0, sq[WIDTH-1:0]};
   endfunction

   // monitor: posedge samples DUT, negedge mirrors what the DUT saw on start/rst
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         if (pending && !rst) begin
            if (done) begin
               e = exp_q.pop_front();
               check("result_out", out, e[WIDTH-1:0]);
               check("result_error", {31'd0, error}, {31'd0, e[WIDTH]});
               check("latency", 32'(edges), 32'(e[EW-1:WIDTH+1]));
               check("busy_at_done", {31'd0, busy}, 32'd0);
               model_out = e[WIDTH-1:0];
               pending = 1'b0;
            end else if (edges > 40) begin
               check("done_timeout", 32'd0, 32'd1);
               void'(exp_q.pop_front());
               pending = 1'b0;
            end else begin
               check("busy_while_calc", {31'd0, busy}, 32'd1);
               check("out_hold", out, model_out);
               check("error_while_calc", {31'd0, error}, 32'd0);
            end
         end
         @(negedge clk);
         if (rst) begin
            pending = 1'b0;
            exp_q.delete();
            model_out = '0;
         end else if (start) begin
            if (pending) void'(exp_q.pop_front());
            pending = 1'b1;
            edges = 0;
         end else if (pending) begin
            edges++;
         end
      end
   end

   // driver tasks
   task automatic issue(input logic [WIDTH-1:0] v);
      @(posedge clk);
      #2;
      start = 1'b1;
      in    = v;
      exp_q.push_back(model(v));
      @(posedge clk);
      #2;
      start = 1'b0;
      in    = $urandom;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && pending; i++) @(posedge clk);
      if (pending) check("wait_idle_timeout", 32'd0, 32'd1);
      @(posedge clk);
   endtask

   task automatic check_zero(input string name);
      check({name, "_out"}, out, '0);
      check({name, "_error"}, {31'd0, error}, 32'd0);
      check({name, "_done"}, {31'd0, done}, 32'd0);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] v;
      rst   = 1'b1;
      start = 1'b0;
      in    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      #1;
      rst = 1'b0;

      // directed
      issue(32'd12);         wait_idle();
      issue(32'd65535);      wait_idle();
      issue(32'h0001_0000);  wait_idle();
      issue(32'h8000_0000);  wait_idle();
      issue(32'd3);          wait_idle();
      issue(32'd0);          wait_idle();
      issue(32'd5);          wait_idle();

      // restart during CALC: 5th CALC edge carries the new start
      issue(32'd5);
      repeat (3) @(posedge clk);
      issue(32'd7);
      wait_idle();

      // start held high for several edges, only the last operand completes
      @(posedge clk);
      #2;
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         in    = 32'(100 + i);
         exp_q.push_back(model(in));
         @(posedge clk);
         #2;
      end
      start = 1'b0;
      wait_idle();

      // reset mid-operation
      issue(32'd1234);
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero("mid_reset");
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check_zero("after_reset");

      // randomized, with occasional aborts
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = WIDTH'($urandom_range(0, 255));
            default: v = WIDTH'($urandom_range(0, 65535));
         endcase
         issue(v);
         if ($urandom_range(0, 4) == 0) repeat ($urandom_range(0, 10)) @(posedge clk);
         else wait_idle();
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
